// File: rtl/shift_seq_ctrl_if.sv
// Request/result bundle between the control unit (master) and the shift sequencer (slave).
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
);
    logic             start;
    logic [1:0]       op;
    logic [CNT_W-1:0] shamt;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, op, shamt, din,
        input  busy, done, dout
    );

    modport slave (
        input  start, op, shamt, din,
        output busy, done, dout
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer applying one 1-bit step per clock.
// Optional rotate-right (op=11) is built only when SHIFT_ROT_EN is defined.
module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] step_val;
    logic             no_shift;

    always_comb begin
        step_val = dout_q;
        case (op_q)
            2'b00: step_val = {dout_q[WIDTH-2:0], 1'b0};
            2'b01: step_val = {1'b0, dout_q[WIDTH-1:1]};
            2'b10: step_val = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
            2'b11: begin
`ifdef SHIFT_ROT_EN
                step_val = {dout_q[0], dout_q[WIDTH-1:1]};
`else
                step_val = dout_q;
`endif
            end
            default: step_val = dout_q;
        endcase
    end

    // Without rotate support, op=11 completes like a zero-amount request.
    always_comb begin
`ifdef SHIFT_ROT_EN
        no_shift = (bus.shamt == '0);
`else
        no_shift = (bus.shamt == '0) || (bus.op == 2'b11);
`endif
    end

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        count_d = count_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.op;
                    dout_d = bus.din;
                    if (no_shift) begin
                        count_d = '0;
                        state_d = S_DONE;
                    end else begin
                        count_d = bus.shamt;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                dout_d = step_val;
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end
                if (count_q <= CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dout_q  <= '0;
            count_q <= '0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.dout = dout_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases plus randomized requests
// compared against an arithmetic shift/rotate reference model.
module tb_shift_seq_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    shift_seq_ctrl_if #(.WIDTH(32), .CNT_W(5)) bus ();

    shift_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Number of single-bit steps the request really performs.
    function automatic int eff_n(input logic [1:0] op, input logic [4:0] sh);
`ifndef SHIFT_ROT_EN
        if (op == 2'b11) return 0;
`endif
        return int'(sh);
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input int n, input logic [31:0] d);
        logic [31:0] r;
        case (op)
            2'b00:   r = d << n;
            2'b01:   r = d >> n;
            2'b10:   r = $signed(d) >>> n;
            default: r = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
        endcase
        return r;
    endfunction

    // Entered and left at a falling edge with the DUT idle.
    task automatic run_op(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] d,
                          input bit hammer, input string tag);
        int          n;
        logic [31:0] exp;
        n   = eff_n(op, sh);
        exp = ref_result(op, n, d);
        bus.start = 1'b1;
        bus.op    = op;
        bus.shamt = sh;
        bus.din   = d;
        @(posedge clk);
        for (int j = 0; j <= n; j++) begin
            @(negedge clk);
            chk({tag, " busy"}, 32'(bus.busy), 32'd1);
            chk({tag, " done"}, 32'(bus.done), (j == n) ? 32'd1 : 32'd0);
            if (j == n) chk({tag, " dout"}, bus.dout, exp);
            bus.start = (hammer && j < n) ? 1'b1 : 1'b0;
            bus.op    = 2'($urandom_range(0, 3));
            bus.shamt = 5'($urandom_range(0, 31));
            bus.din   = $urandom;
        end
        @(negedge clk);
        chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " idle done"}, 32'(bus.done), 32'd0);
        chk({tag, " hold dout"}, bus.dout, exp);
        $display("%s op=%0d shamt=%0d din=%h dout=%h exp=%h hammer=%0d",
                 tag, op, sh, d, bus.dout, exp, hammer);
    endtask

    initial begin
        logic [31:0] rd;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.shamt = '0;
        bus.din   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset dout", bus.dout, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 5'd4,  32'h0000_0001, 1'b0, "sll4");
        run_op(2'b10, 5'd31, 32'h8000_0000, 1'b0, "sra31");
        run_op(2'b01, 5'd31, 32'h8000_0000, 1'b0, "srl31");
        run_op(2'b00, 5'd31, 32'hFFFF_FFFF, 1'b0, "sll31");
        for (int o = 0; o < 4; o++) begin
            run_op(2'(o), 5'd0, 32'hDEAD_BEEF, 1'b0, "zero");
        end
        run_op(2'b10, 5'd7, 32'h9234_5678, 1'b1, "hammer");
        run_op(2'b11, 5'd1, 32'h0000_0003, 1'b0, "op11");

        // Abort an SRL by 10 with a one-cycle reset pulse.
        rd = $urandom | 32'h8000_0000;
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.shamt = 5'd10;
        bus.din   = rd;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort dout", bus.dout, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post-abort done", 32'(bus.done), 32'd0);
        end
        run_op(2'b01, 5'd10, rd, 1'b0, "after-abort");

        for (int t = 0; t < 40; t++) begin
            run_op(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom,
                   1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
